exc_sequencer: RTL and testbench

Exception/interrupt sequencer that drives the 4-bit one-hot `exceptions` vector consumed by the control unit. Captures memory-stage faults (empty-stack access, invalid address) and external interrupt requests, and arbitrates among them. Holds the selected code for the cycles the control unit needs to redirect the pipeline. Records the PC to resume from in `epc`.

---
 rtl/exc_sequencer.sv | 120 ++++++++++++
 tb/tb_exc_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// exc_sequencer: arbitrates memory-stage faults and external interrupts and
// drives a one-hot exception code that the control unit uses to redirect the
// pipeline. All outputs are registered. The saved resume PC is held in epc.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting; accepts mem_err > stack_err > interrupt (not stalled)
//   FAULT | drives latched fault code for HOLD_CYCLES cycles
//   INT1  | drives interrupt phase 1 (4'b0100) for one cycle
//   INT2  | drives interrupt phase 2 (4'b1000) and int_ack for one cycle
//   GAP   | exceptions = 0 for one cycle before returning to IDLE
module exc_sequencer #(
  parameter int PC_W        = 32,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stack_err,
  input  logic            mem_err,
  input  logic            int_req,
  input  logic [PC_W-1:0] err_pc,
  input  logic [PC_W-1:0] cur_pc,
  input  logic            stall,
  output logic [3:0]      exceptions,
  output logic [PC_W-1:0] epc,
  output logic            busy,
  output logic            int_ack,
  output logic            fault_lost
);

  typedef enum logic [2:0] {IDLE, FAULT, INT1, INT2, GAP} state_t;

  localparam logic [2:0] HOLD_INIT = 3'(HOLD_CYCLES);

  state_t     state;
  logic [2:0] hold_cnt;
  logic       int_req_q;
  logic       int_pend;
  logic       int_edge;
  logic       fault_in;

  assign int_edge = int_req & ~int_req_q;
  assign fault_in = stack_err | mem_err;

  // Registered copy of int_req for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) int_req_q <= 1'b0;
    else       int_req_q <= int_req;
  end

  // Sequencer FSM with registered outputs and pending-interrupt bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= 3'd0;
      int_pend   <= 1'b0;
      exceptions <= 4'b0000;
      epc        <= '0;
      busy       <= 1'b0;
      int_ack    <= 1'b0;
      fault_lost <= 1'b0;
    end else begin
      // While a sequence runs, faults are dropped and interrupt edges queue up.
      if (state != IDLE) begin
        if (fault_in) fault_lost <= 1'b1;
        if (int_edge) int_pend   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (fault_in) begin
            exceptions <= mem_err ? 4'b0010 : 4'b0001;
            epc        <= err_pc;
            hold_cnt   <= HOLD_INIT;
            state      <= FAULT;
            busy       <= 1'b1;
            if (mem_err && stack_err) fault_lost <= 1'b1;
            if (int_edge)             int_pend   <= 1'b1;
          end else if ((int_pend || int_edge) && !stall) begin
            exceptions <= 4'b0100;
            epc        <= cur_pc;
            int_pend   <= 1'b0;
            state      <= INT1;
            busy       <= 1'b1;
          end else if (int_edge) begin
            int_pend <= 1'b1;
          end
        end
        FAULT: begin
          hold_cnt <= hold_cnt - 3'd1;
          if (hold_cnt == 3'd1) begin
            exceptions <= 4'b0000;
            state      <= GAP;
          end
        end
        INT1: begin
          exceptions <= 4'b1000;
          int_ack    <= 1'b1;
          state      <= INT2;
        end
        INT2: begin
          exceptions <= 4'b0000;
          int_ack    <= 1'b0;
          state      <= GAP;
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          exceptions <= 4'b0000;
          int_ack    <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Testbench for exc_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_exc_sequencer;

  localparam int PC_W = 32;
  localparam int HOLD = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stack_err = 1'b0;
  logic            mem_err = 1'b0;
  logic            int_req = 1'b0;
  logic            stall = 1'b0;
  logic [PC_W-1:0] err_pc = '0;
  logic [PC_W-1:0] cur_pc = '0;
  logic [3:0]      exceptions;
  logic [PC_W-1:0] epc;
  logic            busy;
  logic            int_ack;
  logic            fault_lost;

  int n_vec = 0;
  int n_bad = 0;

  exc_sequencer #(.PC_W(PC_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .stack_err(stack_err), .mem_err(mem_err),
    .int_req(int_req), .err_pc(err_pc), .cur_pc(cur_pc), .stall(stall),
    .exceptions(exceptions), .epc(epc), .busy(busy), .int_ack(int_ack),
    .fault_lost(fault_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        se, me, ir, st;
    logic [31:0] ep, cp;
    logic [3:0]  e_exc;
    logic        e_busy, e_ack, e_lost;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_exc, input logic e_busy,
                            input logic e_ack, input logic e_lost, input logic [31:0] e_epc);
    chk({tag, ".exceptions"}, 32'(exceptions), 32'(e_exc));
    chk({tag, ".busy"},       32'(busy),       32'(e_busy));
    chk({tag, ".int_ack"},    32'(int_ack),    32'(e_ack));
    chk({tag, ".fault_lost"}, 32'(fault_lost), 32'(e_lost));
    chk({tag, ".epc"},        epc,             e_epc);
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, return at the next negedge.
  task automatic cyc(input logic se, input logic me, input logic ir, input logic st,
                     input logic [31:0] ep, input logic [31:0] cp);
    stack_err = se; mem_err = me; int_req = ir; stall = st; err_pc = ep; cur_pc = cp;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stack_err = 1'b0; mem_err = 1'b0; int_req = 1'b0; stall = 1'b0;
    err_pc = '0; cur_pc = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: an accepted event schedules its whole output sequence
  // as a queue of {int_ack, exceptions} entries; busy means something is being driven.
  logic [4:0] m_q[$];
  logic [4:0] m_cur;
  logic       m_busy, m_pend, m_prev, m_lost;
  logic [31:0] m_epc;

  task automatic model_reset();
    m_q.delete();
    m_cur = '0; m_busy = 0; m_pend = 0; m_prev = 0; m_lost = 0; m_epc = '0;
  endtask

  task automatic model_step(input logic se, input logic me, input logic ir, input logic st,
                            input logic [31:0] ep, input logic [31:0] cp);
    logic edge_seen;
    edge_seen = ir && !m_prev;
    m_prev = ir;
    if (m_busy) begin
      if (se || me) m_lost = 1;
      if (edge_seen) m_pend = 1;
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else begin m_cur = '0; m_busy = 0; end
    end else if (se || me) begin
      if (se && me) m_lost = 1;
      if (edge_seen) m_pend = 1;
      m_epc = ep;
      for (int i = 0; i < HOLD; i++) m_q.push_back(me ? 5'b0_0010 : 5'b0_0001);
      m_q.push_back(5'b0_0000);
      m_cur = m_q.pop_front();
      m_busy = 1;
    end else if ((m_pend || edge_seen) && !st) begin
      m_epc = cp;
      m_pend = 0;
      m_q.push_back(5'b0_0100);
      m_q.push_back(5'b1_1000);
      m_q.push_back(5'b0_0000);
      m_cur = m_q.pop_front();
      m_busy = 1;
    end else if (edge_seen) begin
      m_pend = 1;
    end
  endtask

  initial begin
    vecs[0]  = '{0,1,0,0,32'h40,32'h0,   4'b0010,1,0,0,32'h40};
    vecs[1]  = '{0,0,0,0,32'h0, 32'h0,   4'b0010,1,0,0,32'h40};
    vecs[2]  = '{0,0,0,0,32'h0, 32'h0,   4'b0000,1,0,0,32'h40};
    vecs[3]  = '{0,0,0,0,32'h0, 32'h0,   4'b0000,0,0,0,32'h40};
    vecs[4]  = '{1,1,0,0,32'h10,32'h0,   4'b0010,1,0,1,32'h10};
    vecs[5]  = '{0,0,0,0,32'h0, 32'h0,   4'b0010,1,0,1,32'h10};
    vecs[6]  = '{0,0,0,0,32'h0, 32'h0,   4'b0000,1,0,1,32'h10};
    vecs[7]  = '{0,0,0,0,32'h0, 32'h0,   4'b0000,0,0,1,32'h10};
    vecs[8]  = '{0,0,1,0,32'h0, 32'h200, 4'b0100,1,0,1,32'h200};
    vecs[9]  = '{0,0,1,0,32'h0, 32'h200, 4'b1000,1,1,1,32'h200};
    vecs[10] = '{0,0,1,0,32'h0, 32'h200, 4'b0000,1,0,1,32'h200};
    vecs[11] = '{0,0,1,0,32'h0, 32'h200, 4'b0000,0,0,1,32'h200};

    // Reset state
    @(negedge clk);
    expect_out("reset", 4'b0000, 0, 0, 0, 32'h0);
    do_reset();

    // Directed table: mem fault, double fault, plain interrupt
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].se, vecs[i].me, vecs[i].ir, vecs[i].st, vecs[i].ep, vecs[i].cp);
      expect_out($sformatf("vec%0d", i), vecs[i].e_exc, vecs[i].e_busy,
                 vecs[i].e_ack, vecs[i].e_lost, vecs[i].e_epc);
    end

    // Interrupt edge during a fault hold is served after GAP and an IDLE cycle
    do_reset();
    cyc(0,1,0,0,32'h80,32'h300); expect_out("fi0", 4'b0010,1,0,0,32'h80);
    cyc(0,0,1,0,32'h0, 32'h300); expect_out("fi1", 4'b0010,1,0,0,32'h80);
    cyc(0,0,1,0,32'h0, 32'h300); expect_out("fi2", 4'b0000,1,0,0,32'h80);
    cyc(0,0,1,0,32'h0, 32'h300); expect_out("fi3", 4'b0000,0,0,0,32'h80);
    cyc(0,0,1,0,32'h0, 32'h300); expect_out("fi4", 4'b0100,1,0,0,32'h300);
    cyc(0,0,1,0,32'h0, 32'h300); expect_out("fi5", 4'b1000,1,1,0,32'h300);
    cyc(0,0,0,0,32'h0, 32'h300); expect_out("fi6", 4'b0000,1,0,0,32'h300);
    cyc(0,0,0,0,32'h0, 32'h300); expect_out("fi7", 4'b0000,0,0,0,32'h300);

    // Stall defers interrupt entry
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,1,1,32'h0,32'h500); expect_out($sformatf("stall%0d", i), 4'b0000,0,0,0,32'h0);
    end
    cyc(0,0,1,0,32'h0,32'h500); expect_out("st_int1", 4'b0100,1,0,0,32'h500);
    cyc(0,0,1,0,32'h0,32'h500); expect_out("st_int2", 4'b1000,1,1,0,32'h500);
    cyc(0,0,1,0,32'h0,32'h500); expect_out("st_gap",  4'b0000,1,0,0,32'h500);
    cyc(0,0,0,0,32'h0,32'h500); expect_out("st_idle", 4'b0000,0,0,0,32'h500);

    // Reset during INT1 aborts immediately; no INT2 afterwards
    do_reset();
    cyc(0,0,1,0,32'h0,32'h600); expect_out("ri_int1", 4'b0100,1,0,0,32'h600);
    #2 reset = 1'b1;
    #1 expect_out("ri_async", 4'b0000,0,0,0,32'h0);
    int_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,0,0,32'h0,32'h600); expect_out($sformatf("ri_post%0d", i), 4'b0000,0,0,0,32'h0);
    end

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    begin
      logic se, me, ir, st;
      logic [31:0] ep, cp;
      ir = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        se = ($urandom_range(0, 7) == 0);
        me = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 5) == 0) ir = ~ir;
        st = ($urandom_range(0, 2) == 0);
        ep = $urandom;
        cp = $urandom;
        model_step(se, me, ir, st, ep, cp);
        cyc(se, me, ir, st, ep, cp);
        expect_out($sformatf("rnd%0d", i), m_cur[3:0], m_busy, m_cur[4], m_lost, m_epc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
